fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//  Instruction queue between fetch_stage and the decode stage. Buffers up to
//  DEPTH {pc, instruction, itlb_miss} entries so cache-hit fetches keep flowing
//  while decode stalls. Drives fetch back-pressure into the fetch EN_REG input.
//  On flush (branch redirect / exception) it drops all in-flight entries.
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  DATA_W  32  width of pc and instruction fields
// PORTS
//  clk            in   1       single clock, rising edge
//  reset          in   1       asynchronous, active-high
//  flush          in   1       drop all entries this edge
//  fetch_valid    in   1       fetch presents a valid instruction (cache hit)
//  fetch_pc       in   DATA_W  PCnext of that instruction
//  fetch_instr    in   DATA_W  instruction word
//  fetch_itlb_miss in  1       iTLB miss flag travelling with the entry
//  fetch_stall    out  1       1 = queue full; fetch must hold PC
//  dec_ready      in   1       decode consumes head this cycle
//  dec_valid      out  1       head entry valid
//  dec_pc         out  DATA_W  head pc
//  dec_instr      out  DATA_W  head instruction; NOP_INSTR when empty
//  dec_itlb_miss  out  1       head iTLB-miss flag; 0 when empty
//  occupancy      out  log2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  - Storage: circular buffer, wr_ptr/rd_ptr of log2(DEPTH)+1 bits (MSB = wrap).
//    empty = ptrs equal; full = low bits equal, MSBs differ.
//  - Reset (async, immediate): ptrs=0, occupancy=0, fetch_stall=0,
//    dec_valid=0, dec_pc=0, dec_instr=NOP_INSTR, dec_itlb_miss=0.
//    Storage contents need no reset.
//  - push = fetch_valid && (!full || pop); pop = dec_valid && dec_ready.
//  - Latency: a pushed entry is visible at dec_* the cycle after the push edge
//    (no same-cycle fall-through). Outputs are decoded from registered state only.
//  - Full + pop + fetch_valid same cycle: both happen; occupancy stays DEPTH.
//  - Empty + dec_ready: no pop, no pointer move; dec_ready is ignored.
//  - fetch_valid while full and no pop: entry is dropped by the queue. fetch_stall
//    is asserted throughout, so a compliant fetch never does this; assertion flags it.
//  - Push and pop same cycle, not full: occupancy unchanged, both ptrs advance.
//  - flush: highest priority after reset; next edge sets rd_ptr=wr_ptr=0,
//    occupancy=0. Concurrent push and pop are discarded. Outputs return to the
//    empty values the following cycle.
//  - fetch_stall = full (registered-state decode). It is not lowered by a
//    same-cycle pop; fetch resumes one cycle later.
//  - Pointer wrap: low bits wrap modulo DEPTH, MSB toggles; occupancy =
//    wr_ptr - rd_ptr (mod 2*DEPTH), never exceeds DEPTH.
//  - Reset asserted mid-operation: all state cleared immediately; in-flight
//    entries are lost.
// STRUCTURE
//  - Shared package cpu_pkg: NOP_INSTR constant (32'h0000_0000, the codebase NOP),
//    typedef fdq_entry_t {logic [31:0] pc; logic [31:0] instr; logic itlb_miss;}.
//  - One natural sub-module: fdq_ptr_ctrl (pointers, full/empty, occupancy);
//    storage array and output muxing stay in the top.
//  - SVA: no push while full without pop; occupancy <= DEPTH; dec_valid == !empty.
// TESTING
//  1. Reset, then 3 pushes pc=0x4,0x8,0xC, dec_ready=0 -> occupancy=3,
//     dec_valid=1, dec_pc=0x4, fetch_stall=0.
//  2. Fill 4 entries, dec_ready=0 -> fetch_stall=1 from next cycle. Hold a 5th
//     fetch_valid -> no change. Then 1 pop -> stall=0 one cycle later.
//  3. Full, pop + push pc=0x20 same cycle -> occupancy stays 4;
//     0x20 emerges after the 3 older entries.
//  4. 10 push/pop pairs, crossing the pointer wrap -> in-order pcs 0x4..0x28,
//     occupancy never > 4.
//  5. 3 entries held, flush together with fetch_valid (pc=0x40) and dec_ready ->
//     next cycle occupancy=0, dec_valid=0, dec_instr=NOP_INSTR; 0x40 is absent.
//  6. Async reset pulse mid-stream with 2 entries held -> outputs return to reset
//     values before the next clk edge; push itlb_miss=1 afterwards ->
//     dec_itlb_miss=1 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the codebase NOP encoding and the fetch->decode queue entry.
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        itlb_miss;
  } fdq_entry_t;
endpackage

// File: rtl/fdq_ptr_ctrl.sv
// Pointer bookkeeping for the fetch/decode queue: wrap-bit pointers, full/empty,
// occupancy, and the qualified push/pop strobes used by the storage array.
module fdq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          i_push_req,
  input  logic          i_pop_req,
  output logic          o_push,
  output logic          o_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW-1:0] o_wr_idx,
  output logic [AW-1:0] o_rd_idx,
  output logic [AW:0]   o_occupancy
);
  logic [AW:0] r_wr_ptr, r_rd_ptr;

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_pop       = i_pop_req && !o_empty;
  assign o_push      = i_push_req && (!o_full || o_pop);
  assign o_wr_idx    = r_wr_ptr[AW-1:0];
  assign o_rd_idx    = r_rd_ptr[AW-1:0];
  // Modulo 2*DEPTH subtraction is exact because the wrap bit disambiguates full.
  assign o_occupancy = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (o_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Head is read straight from the
// storage registers, so a pushed entry appears one cycle after its push edge.
module fetch_decode_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              fetch_valid,
  input  logic [DATA_W-1:0] fetch_pc,
  input  logic [DATA_W-1:0] fetch_instr,
  input  logic              fetch_itlb_miss,
  output logic              fetch_stall,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_pc,
  output logic [DATA_W-1:0] dec_instr,
  output logic              dec_itlb_miss,
  output logic [AW:0]       occupancy
);
  logic          w_push, w_pop, w_full, w_empty;
  logic [AW-1:0] w_wr_idx, w_rd_idx;
  fdq_entry_t    r_mem [DEPTH];
  fdq_entry_t    w_head, w_wr_entry;

  fdq_ptr_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .i_push_req  (fetch_valid),
    .i_pop_req   (dec_ready),
    .o_push      (w_push),
    .o_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_wr_idx    (w_wr_idx),
    .o_rd_idx    (w_rd_idx),
    .o_occupancy (occupancy)
  );

  assign w_wr_entry.pc        = 32'(fetch_pc);
  assign w_wr_entry.instr     = 32'(fetch_instr);
  assign w_wr_entry.itlb_miss = fetch_itlb_miss;

  // Storage is data-only; validity comes from the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[w_wr_idx] <= w_wr_entry;
  end

  assign w_head        = r_mem[w_rd_idx];
  assign fetch_stall   = w_full;
  assign dec_valid     = !w_empty;
  assign dec_pc        = w_empty ? '0 : w_head.pc[DATA_W-1:0];
  assign dec_instr     = w_empty ? DATA_W'(NOP_INSTR) : w_head.instr[DATA_W-1:0];
  assign dec_itlb_miss = w_empty ? 1'b0 : w_head.itlb_miss;

  a_no_drop: assert property (@(posedge clk) disable iff (reset)
    !(fetch_valid && w_full && !w_pop && !flush))
    else $warning("fdq: fetch_valid while full without pop, entry dropped");
  a_occ_max: assert property (@(posedge clk) disable iff (reset)
    occupancy <= (AW+1)'(DEPTH));
  a_valid:   assert property (@(posedge clk) disable iff (reset)
    dec_valid == !w_empty);
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: one task per scenario, inline checks.
module tb_fetch_decode_queue;
  logic        clk = 1'b0;
  logic        reset, flush, fetch_valid, fetch_itlb_miss, dec_ready;
  logic [31:0] fetch_pc, fetch_instr;
  logic        fetch_stall, dec_valid, dec_itlb_miss;
  logic [31:0] dec_pc, dec_instr;
  logic [2:0]  occupancy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_itlb_miss(fetch_itlb_miss), .fetch_stall(fetch_stall),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_instr(dec_instr), .dec_itlb_miss(dec_itlb_miss), .occupancy(occupancy)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1300_0000 | pc;
  endfunction

  // Advance one edge; leaves time at posedge+1 where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    flush = 0; fetch_valid = 0; fetch_pc = 0; fetch_instr = 0;
    fetch_itlb_miss = 0; dec_ready = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; #3; reset = 0; tick();
  endtask

  task automatic push(input logic [31:0] pc);
    fetch_valid = 1; fetch_pc = pc; fetch_instr = instr_of(pc); tick();
    fetch_valid = 0;
  endtask

  // Pop the expected sequence one at a time, checking the head before each pop.
  task automatic drain(input string nm, input logic [31:0] exp_q[$]);
    foreach (exp_q[i]) begin
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_q[i] || dec_instr !== instr_of(exp_q[i])) begin
        errors++;
        $display("FAIL %s[%0d]: got v=%b pc=%h instr=%h, want pc=%h instr=%h",
                 nm, i, dec_valid, dec_pc, dec_instr, exp_q[i], instr_of(exp_q[i]));
      end
      dec_ready = 1; tick(); dec_ready = 0;
    end
    checks++;
    if (dec_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL %s_empty: got v=%b occ=%0d, want v=0 occ=0", nm, dec_valid, occupancy);
    end
  endtask

  task automatic test_reset();
    idle(); reset = 1; #12;
    checks++;
    if (occupancy !== 0 || fetch_stall !== 0 || dec_valid !== 0 || dec_pc !== 0 ||
        dec_instr !== 32'h0 || dec_itlb_miss !== 0) begin
      errors++;
      $display("FAIL reset: got occ=%0d stall=%b v=%b pc=%h instr=%h miss=%b, want all 0",
               occupancy, fetch_stall, dec_valid, dec_pc, dec_instr, dec_itlb_miss);
    end
    reset = 0; tick();
  endtask

  task automatic test_fill3();
    do_reset();
    push(32'h4); push(32'h8); push(32'hC);
    checks++;
    if (occupancy !== 3'd3 || dec_valid !== 1 || dec_pc !== 32'h4 || fetch_stall !== 0) begin
      errors++;
      $display("FAIL fill3: got occ=%0d v=%b pc=%h stall=%b, want 3 1 00000004 0",
               occupancy, dec_valid, dec_pc, fetch_stall);
    end
    drain("fill3_drain", '{32'h4, 32'h8, 32'hC});
  endtask

  task automatic test_full_stall();
    do_reset();
    push(32'h10); push(32'h14); push(32'h18);
    checks++;
    if (fetch_stall !== 0) begin
      errors++; $display("FAIL stall_at3: got %b want 0", fetch_stall);
    end
    push(32'h1C);
    checks++;
    if (fetch_stall !== 1 || occupancy !== 3'd4) begin
      errors++; $display("FAIL stall_at4: got stall=%b occ=%0d want 1 4", fetch_stall, occupancy);
    end
    push(32'h99);
    checks++;
    if (fetch_stall !== 1 || occupancy !== 3'd4 || dec_pc !== 32'h10) begin
      errors++;
      $display("FAIL stall_hold5: got stall=%b occ=%0d pc=%h want 1 4 00000010",
               fetch_stall, occupancy, dec_pc);
    end
    dec_ready = 1; tick(); dec_ready = 0;
    checks++;
    if (fetch_stall !== 0 || occupancy !== 3'd3 || dec_pc !== 32'h14) begin
      errors++;
      $display("FAIL stall_release: got stall=%b occ=%0d pc=%h want 0 3 00000014",
               fetch_stall, occupancy, dec_pc);
    end
    drain("stall_drain", '{32'h14, 32'h18, 32'h1C});
  endtask

  task automatic test_full_pop_push();
    do_reset();
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C);
    fetch_valid = 1; fetch_pc = 32'h20; fetch_instr = instr_of(32'h20); dec_ready = 1;
    checks++;
    if (fetch_stall !== 1) begin
      errors++; $display("FAIL fpp_stall_pre: got %b want 1", fetch_stall);
    end
    tick(); idle();
    checks++;
    if (occupancy !== 3'd4 || fetch_stall !== 1 || dec_pc !== 32'h14) begin
      errors++;
      $display("FAIL fpp_occ: got occ=%0d stall=%b pc=%h want 4 1 00000014",
               occupancy, fetch_stall, dec_pc);
    end
    drain("fpp_drain", '{32'h14, 32'h18, 32'h1C, 32'h20});
  endtask

  task automatic test_wrap();
    logic [31:0] pc;
    do_reset();
    push(32'h4);
    for (int k = 1; k <= 9; k++) begin
      pc = 32'(4 * (k + 1));
      fetch_valid = 1; fetch_pc = pc; fetch_instr = instr_of(pc); dec_ready = 1;
      tick();
      checks++;
      if (occupancy !== 3'd1 || dec_pc !== pc || dec_instr !== instr_of(pc)) begin
        errors++;
        $display("FAIL wrap[%0d]: got occ=%0d pc=%h want 1 %h", k, occupancy, dec_pc, pc);
      end
    end
    idle();
    drain("wrap_last", '{32'h28});
  endtask

  task automatic test_flush();
    do_reset();
    push(32'h30); push(32'h34); push(32'h38);
    flush = 1; fetch_valid = 1; fetch_pc = 32'h40; fetch_instr = instr_of(32'h40); dec_ready = 1;
    tick(); idle();
    checks++;
    if (occupancy !== 0 || dec_valid !== 0 || dec_instr !== 32'h0 || dec_pc !== 0 || fetch_stall !== 0) begin
      errors++;
      $display("FAIL flush: got occ=%0d v=%b instr=%h pc=%h stall=%b want empty",
               occupancy, dec_valid, dec_instr, dec_pc, fetch_stall);
    end
    tick();
    checks++;
    if (dec_valid !== 0 || occupancy !== 0) begin
      errors++; $display("FAIL flush_absent: got v=%b occ=%0d want 0 0", dec_valid, occupancy);
    end
    push(32'h44);
    drain("flush_after", '{32'h44});
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_itlb_miss = 1; push(32'h50); fetch_itlb_miss = 0; push(32'h54);
    checks++;
    if (occupancy !== 3'd2 || dec_itlb_miss !== 1) begin
      errors++; $display("FAIL ar_pre: got occ=%0d miss=%b want 2 1", occupancy, dec_itlb_miss);
    end
    reset = 1; #2;
    checks++;
    if (occupancy !== 0 || dec_valid !== 0 || dec_pc !== 0 || dec_instr !== 32'h0 ||
        dec_itlb_miss !== 0 || fetch_stall !== 0) begin
      errors++;
      $display("FAIL async_reset: got occ=%0d v=%b pc=%h instr=%h miss=%b stall=%b want all 0",
               occupancy, dec_valid, dec_pc, dec_instr, dec_itlb_miss, fetch_stall);
    end
    #1 reset = 0;
    fetch_itlb_miss = 1; push(32'h60); fetch_itlb_miss = 0;
    checks++;
    if (dec_itlb_miss !== 1 || dec_pc !== 32'h60 || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL ar_miss: got miss=%b pc=%h occ=%0d want 1 00000060 1",
               dec_itlb_miss, dec_pc, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_fill3();
    test_full_stall();
    test_full_pop_push();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
